sad_backend_pipe: RTL
=====================

Name: sad_backend_pipe

Overview:
- Back-end of the core, directly downstream of the MEM/SAD pipeline register.
- Owns the SAD_SADD, SAD_SSAD and SAD_WB pipeline registers.
- Runs the 3-stage packed-byte sum-of-absolute-differences datapath with an internal accumulator.
- Exports each stage's special/WriteRegister/ALUResult triple to the forwarding unit, and pending flags to the hazard unit.

Parameters:
- DATA_W, 32, datapath width; must equal 4 byte lanes.
- REG_W, 5, register-index width.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Stall  in  1  freeze all internal registers
- Flush  in  1  kill the instruction entering SAD_SADD
- MEM_SAD_valid  in  1  incoming instruction valid
- MEM_SAD_special  in  1  incoming instruction writes a register
- MEM_SAD_Op  in  2  00 pass, 01 SAD, 10 SADACC, 11 ACCCLR
- MEM_SAD_WriteRegister  in  REG_W  destination register
- MEM_SAD_ALUResult  in  DATA_W  pass-op result
- MEM_SAD_A  in  DATA_W  packed bytes a3..a0 (a3 = bits 31:24)
- MEM_SAD_B  in  DATA_W  packed bytes b3..b0
- SAD_SADD_special, SAD_SSAD_special, SAD_WB_special  out  1  forwardable result present in that stage
- SAD_SADD_WriteRegister, SAD_SSAD_WriteRegister, SAD_WB_WriteRegister  out  REG_W  destination of that stage
- SAD_SADD_ALUResult, SAD_SSAD_ALUResult, SAD_WB_ALUResult  out  DATA_W  stage value
- SAD_SADD_pending, SAD_SSAD_pending  out  1  SAD-class op in stage; result not yet final
- SAD_WB_valid  out  1  WB-stage instruction valid

Behaviour:
- Reset (async, Reset=0): all stage valid/special/pending/WriteRegister/ALUResult outputs are 0; accumulator is 0. Reset mid-operation discards all in-flight ops.
- Stage registers advance on every rising Clk edge when Stall=0. Stall=1 holds every stage register and the accumulator unchanged. Stall has priority over Flush.
- Flush=1 with Stall=0: SAD_SADD loads a bubble. Later stages advance normally.
- Bubble contents: valid=0, special=0, Op=00, WriteRegister=0, ALUResult=0.
- Latency: an op captured into SAD_SADD at edge N is in SAD_SSAD at N+1 and SAD_WB at N+2.
- SAD_SADD stage:
  - Pass op: ALUResult = MEM_SAD_ALUResult.
  - SAD-class op: ALUResult = packed |ai-bi| per byte, unsigned 8-bit, lane i in bits 8i+7:8i.
- SAD_SSAD stage:
  - Pass op: value carried unchanged.
  - SAD-class op: ALUResult = zero-extended sum of the four lanes; max 1020, 10 bits.
- SAD_WB stage:
  - Pass op: value carried unchanged.
  - SAD: result = sum.
  - SADACC: acc <= acc + sum, modulo 2^32, wrap without flag; result = new acc.
  - ACCCLR: acc <= 0; result = 0.
  - The accumulator updates only when the op enters WB with valid=1 and Stall=0.
- Back-to-back SADACC ops chain correctly: each op adds to the accumulator value left by the previous op.
- Output special = valid & special & final:
  - final = 1 for Op=00 in every stage.
  - final = 1 for SAD-class ops only in SAD_WB.
- pending = valid & special & (Op != 00), in SAD_SADD and SAD_SSAD only. It is forced to 0 for bubbles and during reset.
- WriteRegister is carried through every stage unchanged. Register index 0 is carried like any other; the consumer ignores r0.
- No combinational path from inputs to outputs. All outputs are register-driven.

Test Plan:
1. Reset asserted mid-stream with SADACC ops in all stages -> every output is 0 immediately (asynchronously). After release, first SADACC with A=B=0x01010101 (sum 0) -> WB result 0.
2. SAD, Rd=5, A=0x0A141E28, B=0x1410283 2 read as 0x14102832 -> SADD ALUResult=0x0A040A0A with pending=1, special=0. Then SSAD value 0x00000022 with pending=1. Then WB special=1, WriteRegister=5, ALUResult=0x00000022.
3. Pass op, Rd=7, ALUResult=0xDEADBEEF -> special=1 and value 0xDEADBEEF in SADD, then SSAD, then WB on consecutive cycles. Pending stays 0 throughout.
4. ACCCLR followed by three back-to-back SADACC with A=0xFFFFFFFF, B=0 (sum 1020 each) -> WB results 0, 1020, 2040, 3060.
5. Accumulator preloaded to 0xFFFFFF00 via SADACC chain, then SADACC with sum 0x100 -> result 0x00000000, wraps silently.
6. Stall held 3 cycles with ops in all stages -> all outputs and the accumulator are frozen. Flush with Stall=1 -> ignored. Flush with Stall=0 -> SADD becomes a bubble while SSAD and WB advance.

Source files
------------

// File: rtl/sad_backend_pipe_if.sv
// Bundle between the MEM/SAD pipeline register and the SAD back-end, plus the
// per-stage forwarding triples and hazard flags the back-end exports.
interface sad_backend_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              Stall;
  logic              Flush;
  logic              MEM_SAD_valid;
  logic              MEM_SAD_special;
  logic [1:0]        MEM_SAD_Op;
  logic [REG_W-1:0]  MEM_SAD_WriteRegister;
  logic [DATA_W-1:0] MEM_SAD_ALUResult;
  logic [DATA_W-1:0] MEM_SAD_A;
  logic [DATA_W-1:0] MEM_SAD_B;

  logic              SAD_SADD_special;
  logic              SAD_SSAD_special;
  logic              SAD_WB_special;
  logic [REG_W-1:0]  SAD_SADD_WriteRegister;
  logic [REG_W-1:0]  SAD_SSAD_WriteRegister;
  logic [REG_W-1:0]  SAD_WB_WriteRegister;
  logic [DATA_W-1:0] SAD_SADD_ALUResult;
  logic [DATA_W-1:0] SAD_SSAD_ALUResult;
  logic [DATA_W-1:0] SAD_WB_ALUResult;
  logic              SAD_SADD_pending;
  logic              SAD_SSAD_pending;
  logic              SAD_WB_valid;

  modport master (
    output Stall, Flush, MEM_SAD_valid, MEM_SAD_special, MEM_SAD_Op,
           MEM_SAD_WriteRegister, MEM_SAD_ALUResult, MEM_SAD_A, MEM_SAD_B,
    input  SAD_SADD_special, SAD_SSAD_special, SAD_WB_special,
           SAD_SADD_WriteRegister, SAD_SSAD_WriteRegister, SAD_WB_WriteRegister,
           SAD_SADD_ALUResult, SAD_SSAD_ALUResult, SAD_WB_ALUResult,
           SAD_SADD_pending, SAD_SSAD_pending, SAD_WB_valid
  );

  modport slave (
    input  Stall, Flush, MEM_SAD_valid, MEM_SAD_special, MEM_SAD_Op,
           MEM_SAD_WriteRegister, MEM_SAD_ALUResult, MEM_SAD_A, MEM_SAD_B,
    output SAD_SADD_special, SAD_SSAD_special, SAD_WB_special,
           SAD_SADD_WriteRegister, SAD_SSAD_WriteRegister, SAD_WB_WriteRegister,
           SAD_SADD_ALUResult, SAD_SSAD_ALUResult, SAD_WB_ALUResult,
           SAD_SADD_pending, SAD_SSAD_pending, SAD_WB_valid
  );
endinterface

// File: rtl/sad_backend_pipe.sv
// SAD back-end: SADD (per-lane |a-b|), SSAD (lane sum), WB (accumulate/commit).
// Every output comes straight from a flop so forwarding/hazard paths stay short.
module sad_backend_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic               Clk,
  input logic               Reset,
  sad_backend_pipe_if.slave bus
);

  localparam int LANES = DATA_W / 8;
  localparam int SUM_W = 8 + $clog2(LANES);

  typedef enum logic [1:0] {
    OP_PASS   = 2'b00,
    OP_SAD    = 2'b01,
    OP_SADACC = 2'b10,
    OP_ACCCLR = 2'b11
  } sad_op_e;

  typedef struct packed {
    logic              valid;
    logic              special;
    sad_op_e           op;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] value;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t            r_sadd;
  stage_t            r_ssad;
  logic              r_wb_valid;
  logic [REG_W-1:0]  r_wb_wreg;
  logic [DATA_W-1:0] r_wb_value;
  logic [DATA_W-1:0] r_acc;

  logic              r_sadd_fwd;
  logic              r_sadd_pend;
  logic              r_ssad_fwd;
  logic              r_ssad_pend;
  logic              r_wb_fwd;

  stage_t            w_sadd_nxt;
  stage_t            w_ssad_nxt;
  logic [DATA_W-1:0] w_abs_diff;
  logic [SUM_W-1:0]  w_lane_sum;
  logic [DATA_W-1:0] w_acc_sum;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_wb_value;

  // Results of SAD-class ops are not final until WB, so only pass ops forward early.
  function automatic logic early_fwd(input stage_t s);
    return s.valid & s.special & (s.op == OP_PASS);
  endfunction

  function automatic logic sad_pending(input stage_t s);
    return s.valid & s.special & (s.op != OP_PASS);
  endfunction

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    w_abs_diff = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.MEM_SAD_A[8*i +: 8] >= bus.MEM_SAD_B[8*i +: 8])
        w_abs_diff[8*i +: 8] = bus.MEM_SAD_A[8*i +: 8] - bus.MEM_SAD_B[8*i +: 8];
      else
        w_abs_diff[8*i +: 8] = bus.MEM_SAD_B[8*i +: 8] - bus.MEM_SAD_A[8*i +: 8];
    end
  end

  always_comb begin
    w_sadd_nxt = BUBBLE;
    if (!bus.Flush) begin
      w_sadd_nxt.valid   = bus.MEM_SAD_valid;
      w_sadd_nxt.special = bus.MEM_SAD_special;
      w_sadd_nxt.op      = sad_op_e'(bus.MEM_SAD_Op);
      w_sadd_nxt.wreg    = bus.MEM_SAD_WriteRegister;
      w_sadd_nxt.value   = (sad_op_e'(bus.MEM_SAD_Op) == OP_PASS) ? bus.MEM_SAD_ALUResult
                                                                   : w_abs_diff;
    end
  end

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_lane_sum = w_lane_sum + SUM_W'(r_sadd.value[8*i +: 8]);
  end

  always_comb begin
    w_ssad_nxt = r_sadd;
    if (r_sadd.op != OP_PASS)
      w_ssad_nxt.value = DATA_W'(w_lane_sum);
  end

  // The accumulator only moves for a valid op crossing into WB; wrap is silent.
  assign w_acc_sum = r_acc + r_ssad.value;

  always_comb begin
    w_acc_nxt  = r_acc;
    w_wb_value = r_ssad.value;
    unique case (r_ssad.op)
      OP_SADACC: begin
        w_wb_value = w_acc_sum;
        if (r_ssad.valid) w_acc_nxt = w_acc_sum;
      end
      OP_ACCCLR: begin
        w_wb_value = '0;
        if (r_ssad.valid) w_acc_nxt = '0;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all stages sample the pre-edge values together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sadd      <= BUBBLE;
      r_ssad      <= BUBBLE;
      r_wb_valid  <= 1'b0;
      r_wb_wreg   <= '0;
      r_wb_value  <= '0;
      r_acc       <= '0;
      r_sadd_fwd  <= 1'b0;
      r_sadd_pend <= 1'b0;
      r_ssad_fwd  <= 1'b0;
      r_ssad_pend <= 1'b0;
      r_wb_fwd    <= 1'b0;
    end else if (!bus.Stall) begin
      r_sadd      <= w_sadd_nxt;
      r_ssad      <= w_ssad_nxt;
      r_wb_valid  <= r_ssad.valid;
      r_wb_wreg   <= r_ssad.wreg;
      r_wb_value  <= w_wb_value;
      r_acc       <= w_acc_nxt;
      r_sadd_fwd  <= early_fwd(w_sadd_nxt);
      r_sadd_pend <= sad_pending(w_sadd_nxt);
      r_ssad_fwd  <= early_fwd(w_ssad_nxt);
      r_ssad_pend <= sad_pending(w_ssad_nxt);
      r_wb_fwd    <= r_ssad.valid & r_ssad.special;
    end
  end

  assign bus.SAD_SADD_special       = r_sadd_fwd;
  assign bus.SAD_SSAD_special       = r_ssad_fwd;
  assign bus.SAD_WB_special         = r_wb_fwd;
  assign bus.SAD_SADD_WriteRegister = r_sadd.wreg;
  assign bus.SAD_SSAD_WriteRegister = r_ssad.wreg;
  assign bus.SAD_WB_WriteRegister   = r_wb_wreg;
  assign bus.SAD_SADD_ALUResult     = r_sadd.value;
  assign bus.SAD_SSAD_ALUResult     = r_ssad.value;
  assign bus.SAD_WB_ALUResult       = r_wb_value;
  assign bus.SAD_SADD_pending       = r_sadd_pend;
  assign bus.SAD_SSAD_pending       = r_ssad_pend;
  assign bus.SAD_WB_valid           = r_wb_valid;

endmodule
